// File: rtl/alu_sel_pkg.sv
// alu_sel_pkg: ALU result select codes and the beat record for the result selector.
package alu_sel_pkg;
    localparam int BEAT_N = 32;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_AND  = 4'd2;
    localparam logic [3:0] SEL_OR   = 4'd3;
    localparam logic [3:0] SEL_XOR  = 4'd4;
    localparam logic [3:0] SEL_SLL  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_SRA  = 4'd7;
    localparam logic [3:0] SEL_SLT  = 4'd8;
    localparam logic [3:0] SEL_SRC9 = 4'd9;

    typedef struct packed {
        logic [BEAT_N-1:0] result;
        logic              err;
        logic [1:0]        flags;
    } alu_beat_t;
endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: two-entry valid/ready buffer; main entry drives the outputs, skid absorbs one stalled beat.
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic         m_v_q, m_v_d, s_v_q, s_v_d;
    logic [W-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
    logic         acc;

    assign in_ready  = !s_v_q;
    assign acc       = in_valid && !s_v_q;
    assign out_valid = m_v_q;
    assign out_data  = m_dat_q;

    always_comb begin
        m_v_d   = m_v_q;
        m_dat_d = m_dat_q;
        s_v_d   = s_v_q;
        s_dat_d = s_dat_q;
        if (!m_v_q || out_ready) begin
            // A full skid always has priority so ordering stays FIFO
            if (s_v_q) begin
                m_v_d   = 1'b1;
                m_dat_d = s_dat_q;
                s_v_d   = 1'b0;
            end else begin
                m_v_d   = acc;
                m_dat_d = acc ? in_data : m_dat_q;
            end
        end else if (acc) begin
            s_v_d   = 1'b1;
            s_dat_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            m_dat_q <= '0;
            s_dat_q <= '0;
        end else begin
            m_v_q   <= m_v_d;
            s_v_q   <= s_v_d;
            m_dat_q <= m_dat_d;
            s_dat_q <= s_dat_d;
        end
    end
endmodule

// File: rtl/alu_result_sel.sv
// alu_result_sel: registered ALU result mux with error flagging and skid-buffered valid/ready output.
// Optional ALU_RESULT_FLAGS_EN stores {negative, zero} flags alongside each beat.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter int N       = 32,
    parameter int NUM_SRC = 10,
    parameter int SEL_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0][N-1:0] srcs,
    input  logic [SEL_W-1:0]          selec_alu,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N-1:0]              out_result,
    output logic                      out_err,
    output logic [1:0]                out_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err_sticky,
    input  logic                      clr_err
);
`ifdef ALU_RESULT_FLAGS_EN
    localparam int PW = N + 3;
`else
    localparam int PW = N + 1;
`endif

    logic          sel_ok;
    logic [N-1:0]  sel_res;
    logic [PW-1:0] in_pay, out_pay;
    logic          err_sticky_q, err_sticky_d;

    assign sel_ok  = int'(selec_alu) < NUM_SRC;
    assign sel_res = sel_ok ? srcs[selec_alu] : '0;

`ifdef ALU_RESULT_FLAGS_EN
    assign in_pay    = {sel_res[N-1], sel_res == '0, !sel_ok, sel_res};
    assign out_flags = out_pay[N+2:N+1];
`else
    assign in_pay    = {!sel_ok, sel_res};
    assign out_flags = 2'b00;
`endif
    assign out_err    = out_pay[N];
    assign out_result = out_pay[N-1:0];

    alu_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_pay),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_pay),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Set beats clr_err when both happen in one cycle
    always_comb err_sticky_d = (in_valid && in_ready && !sel_ok) || (err_sticky_q && !clr_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_sticky_q <= 1'b0;
        else        err_sticky_q <= err_sticky_d;
    end

    assign err_sticky = err_sticky_q;
endmodule
